gate_tester: RTL and testbench
==============================

# gate_tester

Sequential self-test driver and checker for the two-input basic-gate bank (AND, NAND, OR, NOR, XOR, XNOR, NOT a). It sits on the other end of the gate bank's `a`/`b` → `z0..z6` interface. It drives all four input vectors, waits a programmable settle time, samples the seven outputs, and compares them against the expected truth table. It reports pass/fail, an error count and failure masks, for board bring-up or in-system checking of the gate bank.

## Interface
- `SETTLE_CYCLES`, default 2: extra cycles each vector is held before sampling. Legal range 0..255.
- `LOOP`, default 0: when 1, a new run starts automatically the cycle after `done`.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request, sampled only in IDLE.
- `a`  out  1  gate-bank input a.
- `b`  out  1  gate-bank input b.
- `z`  in  7  gate-bank outputs, bit i = zi:
  - bit 0 AND, bit 1 NAND, bit 2 OR, bit 3 NOR
  - bit 4 XOR, bit 5 XNOR, bit 6 NOT a
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  single-cycle pulse at end of run.
- `pass`  out  1  last completed run had zero mismatches.
- `err_count`  out  3  number of failing vectors in last run, 0..4.
- `fail_mask`  out  4  bit k set if vector k = {a,b} failed.
- `fail_bits`  out  7  OR over the run of mismatching z bit positions.

## Operation
- States:
  - IDLE: waiting for `start`.
  - RUN: driving a vector and counting settle cycles.
  - FINISH: one cycle; publish results, pulse `done`.
- Vector index `idx` is 2 bits, with `{a,b} = idx`. Order is 00, 01, 10, 11. After 11 the run ends; there is no wrap within a run.
- Expected value for vector `{a,b}`: `exp = {~a, ~(a^b), a^b, ~(a|b), a|b, ~(a&b), a&b}`. Compared against `z` bit-for-bit.
- IDLE → RUN on `start` = 1:
  - `idx` ← 0 and settle counter ← `SETTLE_CYCLES`.
  - Internal accumulators cleared.
- RUN, counter ≠ 0: decrement the counter.
- RUN, counter = 0: sample `z` and compare.
  - On mismatch: set `acc_mask[idx]`, increment `acc_err`, OR `(z ^ exp)` into `acc_bits`.
  - If `idx` = 3, go to FINISH.
  - Otherwise `idx` ← `idx`+1 and counter reloads.
- FINISH:
  - Copy the accumulators into the `err_count`, `fail_mask` and `fail_bits` output registers.
  - `pass` ← (`acc_err` == 0).
  - `done` = 1 for this cycle.
  - Next state is IDLE (`LOOP` = 0) or RUN with a fresh run (`LOOP` = 1).
- Result outputs hold their values until the next FINISH. They are not cleared at `start`.
- `start` while `busy` = 1 or in FINISH is ignored and not queued.
- `a`/`b` hold their last vector (11) after a run until the next run starts.
- Accumulators are internal. Published results never show a partial run.

## Timing
- Reset (async assert, sync-style release on the next edge): state = IDLE, `a` = 0, `b` = 0, `busy` = 0, `done` = 0, `pass` = 0, `err_count` = 0, `fail_mask` = 0, `fail_bits` = 0.
- `start` sampled high at edge E0: `a`/`b` = 00 and `busy` = 1 from E0.
- Each vector is driven for `SETTLE_CYCLES`+1 cycles. `z` is sampled at the last edge of that window.
- Total RUN length is 4·(`SETTLE_CYCLES`+1) cycles.
  - With `SETTLE_CYCLES` = 2: samples at edges E3, E6, E9, E12.
  - FINISH (`done` = 1, `busy` = 0) occupies the cycle after E12.
  - Results visible from E13.
- `busy` is high exactly during RUN and is low in FINISH.
- Reset asserted mid-run aborts immediately. All outputs return to reset values, with previous results lost, and no `done` is produced.
- Latency from `start` to `done` is 4·(`SETTLE_CYCLES`+1)+1 edges.

## Test plan
- Behavioural gate-bank model connected, `SETTLE_CYCLES` = 2, pulse `start`:
  - `done` one cycle, 13 edges after `start`.
  - `pass` = 1, `err_count` = 0, `fail_mask` = 4'b0000, `fail_bits` = 7'b0000000.
  - `a`/`b` sequence 00, 01, 10, 11, each held 3 cycles.
- `z[4]` stuck at 0:
  - `pass` = 0, `err_count` = 2, `fail_mask` = 4'b0110, `fail_bits` = 7'b0010000.
- `z[6]` wired to `b` instead of `~a`:
  - `err_count` = 2, `fail_mask` = 4'b1001, `fail_bits` = 7'b1000000.
- Gate-bank model with one register stage on `z`:
  - `SETTLE_CYCLES` = 0: `pass` = 0, `done` 5 edges after `start`.
  - `SETTLE_CYCLES` = 1: `pass` = 1.
- `start` pulsed again during RUN and during FINISH: ignored, exactly one `done`. `LOOP` = 1: RUN restarts the cycle after `done`, and `done` pulses every 13 cycles.
- `rst_n` low at cycle 7 of a run, after a prior failing run:
  - All outputs are 0 immediately.
  - No `done` appears.
  - A following `start` completes a clean run normally.

Source files
------------

// File: rtl/gate_tester.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | gate_tester: drives all four {a,b} vectors into a two-input gate bank and  |
// | checks z0..z6 against the expected truth table after a settle window.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gate_tester #(
    parameter int SETTLE_CYCLES = 2,
    parameter bit LOOP          = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic [6:0] z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask,
    output logic [6:0] fail_bits
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam logic [7:0] c_settle = 8'(SETTLE_CYCLES);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] acc_err_q, acc_err_d;
    logic [3:0] acc_mask_q, acc_mask_d;
    logic [6:0] acc_bits_q, acc_bits_d;
    logic [2:0] err_count_q, err_count_d;
    logic [3:0] fail_mask_q, fail_mask_d;
    logic [6:0] fail_bits_q, fail_bits_d;
    logic       pass_q, pass_d;
    logic [6:0] w_exp;
    logic       w_a;
    logic       w_b;

    assign w_a   = idx_q[1];
    assign w_b   = idx_q[0];
    assign w_exp = {~w_a, ~(w_a ^ w_b), w_a ^ w_b, ~(w_a | w_b), w_a | w_b, ~(w_a & w_b), w_a & w_b};

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        acc_err_d   = acc_err_q;
        acc_mask_d  = acc_mask_q;
        acc_bits_d  = acc_bits_q;
        err_count_d = err_count_q;
        fail_mask_d = fail_mask_q;
        fail_bits_d = fail_bits_q;
        pass_d      = pass_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    idx_d      = 2'd0;
                    cnt_d      = c_settle;
                    acc_err_d  = 3'd0;
                    acc_mask_d = 4'd0;
                    acc_bits_d = 7'd0;
                end
            end
            ST_RUN: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    if (z != w_exp) begin
                        acc_mask_d[idx_q] = 1'b1;
                        acc_err_d         = acc_err_q + 3'd1;
                        acc_bits_d        = acc_bits_q | (z ^ w_exp);
                    end
                    if (idx_q == 2'd3) begin
                        state_d = ST_FINISH;
                    end else begin
                        idx_d = idx_q + 2'd1;
                        cnt_d = c_settle;
                    end
                end
            end
            ST_FINISH: begin
                // Results only change here, so a partial run is never visible.
                err_count_d = acc_err_q;
                fail_mask_d = acc_mask_q;
                fail_bits_d = acc_bits_q;
                pass_d      = (acc_err_q == 3'd0);
                if (LOOP) begin
                    state_d    = ST_RUN;
                    idx_d      = 2'd0;
                    cnt_d      = c_settle;
                    acc_err_d  = 3'd0;
                    acc_mask_d = 4'd0;
                    acc_bits_d = 7'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            cnt_q       <= 8'd0;
            acc_err_q   <= 3'd0;
            acc_mask_q  <= 4'd0;
            acc_bits_q  <= 7'd0;
            err_count_q <= 3'd0;
            fail_mask_q <= 4'd0;
            fail_bits_q <= 7'd0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            acc_err_q   <= acc_err_d;
            acc_mask_q  <= acc_mask_d;
            acc_bits_q  <= acc_bits_d;
            err_count_q <= err_count_d;
            fail_mask_q <= fail_mask_d;
            fail_bits_q <= fail_bits_d;
            pass_q      <= pass_d;
        end
    end

    assign a         = w_a;
    assign b         = w_b;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_FINISH);
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign fail_mask = fail_mask_q;
    assign fail_bits = fail_bits_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_tester.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gate_tester: table-driven bench with a scoreboard for gate_tester.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_gate_tester;

    typedef struct packed {
        logic       pass;
        logic [2:0] err;
        logic [3:0] mask;
        logic [6:0] bits;
    } res_t;

    typedef struct {
        int   mode;
        res_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Gate-bank truth table, one row per {a,b}: bits 6..0 = NOTa XNOR XOR NOR OR NAND AND
    function automatic logic [6:0] gm(input logic ai, input logic bi);
        case ({ai, bi})
            2'b00:   return 7'b1101010;
            2'b01:   return 7'b1010110;
            2'b10:   return 7'b0010110;
            default: return 7'b0100101;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Main DUT: SETTLE_CYCLES = 2 with a selectable faulty gate-bank model
    logic       start_m = 1'b0;
    logic       a_m, b_m, busy_m, done_m, pass_m;
    logic [2:0] err_m;
    logic [3:0] mask_m;
    logic [6:0] bits_m, z_m, zr_m;
    int         mode_sel = 0;

    always @(posedge clk) zr_m <= gm(a_m, b_m);
    always_comb begin
        z_m = gm(a_m, b_m);
        case (mode_sel)
            1:       z_m[4] = 1'b0;
            2:       z_m[6] = b_m;
            3:       z_m = zr_m;
            default: ;
        endcase
    end

    gate_tester #(.SETTLE_CYCLES(2), .LOOP(1'b0)) dut_m (
        .clk(clk), .rst_n(rst_n), .start(start_m), .a(a_m), .b(b_m), .z(z_m),
        .busy(busy_m), .done(done_m), .pass(pass_m), .err_count(err_m),
        .fail_mask(mask_m), .fail_bits(bits_m)
    );

    // Registered gate bank against SETTLE_CYCLES = 0 and 1
    logic       start_s = 1'b0;
    logic       a_0, b_0, busy_0, done_0, pass_0, a_1, b_1, busy_1, done_1, pass_1;
    logic [2:0] err_0, err_1;
    logic [3:0] mask_0, mask_1;
    logic [6:0] bits_0, bits_1, zr_0, zr_1;
    always @(posedge clk) zr_0 <= gm(a_0, b_0);
    always @(posedge clk) zr_1 <= gm(a_1, b_1);

    gate_tester #(.SETTLE_CYCLES(0), .LOOP(1'b0)) dut_s0 (
        .clk(clk), .rst_n(rst_n), .start(start_s), .a(a_0), .b(b_0), .z(zr_0),
        .busy(busy_0), .done(done_0), .pass(pass_0), .err_count(err_0),
        .fail_mask(mask_0), .fail_bits(bits_0)
    );
    gate_tester #(.SETTLE_CYCLES(1), .LOOP(1'b0)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .start(start_s), .a(a_1), .b(b_1), .z(zr_1),
        .busy(busy_1), .done(done_1), .pass(pass_1), .err_count(err_1),
        .fail_mask(mask_1), .fail_bits(bits_1)
    );

    // Free-running LOOP instance
    logic       start_l = 1'b0;
    logic       a_l, b_l, busy_l, done_l, pass_l;
    logic [2:0] err_l;
    logic [3:0] mask_l;
    logic [6:0] bits_l;
    gate_tester #(.SETTLE_CYCLES(2), .LOOP(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .start(start_l), .a(a_l), .b(b_l), .z(gm(a_l, b_l)),
        .busy(busy_l), .done(done_l), .pass(pass_l), .err_count(err_l),
        .fail_mask(mask_l), .fail_bits(bits_l)
    );

    logic [1:0] ab_q[$];
    res_t       res_q[$];

    task automatic run_main(input int mode, input res_t exp, input bit poke);
        int   dones = 0;
        bit   res_next = 1'b0;
        res_t r;
        logic [1:0] e;
        mode_sel = mode;
        @(negedge clk);
        start_m = 1'b1;
        for (int v = 0; v < 4; v++)
            for (int c = 0; c < 3; c++) ab_q.push_back(2'(v));
        res_q.push_back(exp);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start_m = (poke && k == 5) ? 1'b1 : 1'b0;
            if (res_next) begin
                res_next = 1'b0;
                r = res_q.pop_front();
                chk("result", {pass_m, err_m, mask_m, bits_m}, r);
            end
            if (busy_m) begin
                if (ab_q.size() == 0) chk("unexpected_busy", 1, 0);
                else begin
                    e = ab_q.pop_front();
                    chk("ab_seq", {a_m, b_m}, e);
                end
            end
            if (done_m) begin
                dones++;
                chk("done_latency", k, 13);
                chk("busy_in_finish", busy_m, 0);
                res_next = 1'b1;
                if (poke) start_m = 1'b1;
            end
        end
        start_m = 1'b0;
        chk("done_count", dones, 1);
        chk("ab_hold", {a_m, b_m}, 2'b11);
        chk("queues_empty", ab_q.size() + res_q.size(), 0);
        ab_q.delete();
        res_q.delete();
    endtask

    vec_t tbl[5];
    int   d0, d1, l1, l2;
    bit   lb;

    initial begin
        tbl[0] = '{0, res_t'{1'b1, 3'd0, 4'b0000, 7'b0000000}};
        tbl[1] = '{1, res_t'{1'b0, 3'd2, 4'b0110, 7'b0010000}};
        tbl[2] = '{2, res_t'{1'b0, 3'd2, 4'b1001, 7'b1000000}};
        tbl[3] = '{3, res_t'{1'b1, 3'd0, 4'b0000, 7'b0000000}};
        tbl[4] = '{0, res_t'{1'b1, 3'd0, 4'b0000, 7'b0000000}};

        repeat (3) @(negedge clk);
        chk("reset_state", {a_m, b_m, busy_m, done_m, pass_m, err_m, mask_m, bits_m}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {busy_m, done_m}, 0);

        for (int i = 0; i < 5; i++) run_main(tbl[i].mode, tbl[i].exp, 1'b0);

        // Extra start pulses during RUN and FINISH; leaves a failing result behind
        run_main(1, tbl[1].exp, 1'b1);

        // Reset at cycle 7 of a run aborts it and wipes the previous results
        mode_sel = 0;
        @(negedge clk);
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        repeat (6) @(negedge clk);
        chk("busy_before_abort", busy_m, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {a_m, b_m, busy_m, done_m, pass_m, err_m, mask_m, bits_m}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done_m) d0++;
        end
        chk("no_done_after_abort", d0, 0);
        run_main(0, tbl[0].exp, 1'b0);

        // Registered gate bank: settle 0 fails, settle 1 passes
        d0 = -1;
        d1 = -1;
        @(negedge clk);
        start_s = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start_s = 1'b0;
            if (done_0 && d0 < 0) d0 = k;
            if (done_1 && d1 < 0) d1 = k;
        end
        chk("s0_latency", d0, 5);
        chk("s0_pass", pass_0, 0);
        chk("s1_latency", d1, 9);
        chk("s1_pass", pass_1, 1);

        // LOOP restarts the cycle after done, one done every 13 cycles
        l1 = -1;
        l2 = -1;
        lb = 1'b0;
        @(negedge clk);
        start_l = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start_l = 1'b0;
            if (done_l) begin
                if (l1 < 0) l1 = k;
                else if (l2 < 0) l2 = k;
            end
            if (k == 14) lb = busy_l;
        end
        chk("loop_first_done", l1, 13);
        chk("loop_period", l2 - l1, 13);
        chk("loop_restart_busy", lb, 1);
        chk("loop_pass", pass_l, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
